// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, FSM states and opcode classification for the load/store unit.
// Optional feature macro used elsewhere: LSU_MISALIGN_EXC_EN.
package mem_access_unit_pkg;

  localparam logic [31:0] DATA_LIMIT_DEF = 32'h0000_3000;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and memory data port of the load/store unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: load byte/half extract with sign/zero extension,
// and sub-word store merge into a previously read word (little-endian lanes).
module mem_access_unit_lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [15:0] i_wdata,
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_rdata,
  output logic [31:0] o_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_word[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_rdata = '0;
    case (i_op)
      OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_rdata = {24'd0, w_byte};
      OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_rdata = {16'd0, w_half};
      OP_LW:   o_rdata = i_word;
      default: o_rdata = '0;
    endcase
  end

  always_comb begin
    o_word = i_word;
    case (i_op)
      OP_SB:   o_word[{i_addr_lo, 3'b000} +: 8]     = i_wdata[7:0];
      OP_SH:   o_word[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata;
      default: o_word = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: FSM, request registers and registered memory-side outputs.
// Define LSU_MISALIGN_EXC_EN to reject misaligned half/word accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter logic [31:0] DATA_LIMIT = DATA_LIMIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mem_access_unit_if.slave  bus
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic        w_accept;
  logic        w_req_err;
  logic        w_misalign;
  logic [3:0]  r_op;
  logic [1:0]  r_addr_lo;
  logic [15:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

`ifdef LSU_MISALIGN_EXC_EN
  assign w_misalign =
    (((bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH)) && bus.req_addr[0]) ||
    (((bus.req_op == OP_LW) || (bus.req_op == OP_SW)) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = !(op_is_load(bus.req_op) || op_is_store(bus.req_op)) ||
                     (op_is_store(bus.req_op) && (bus.req_addr >= DATA_LIMIT)) ||
                     w_misalign;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept = 1'b1;
          if (w_req_err)              w_state_nxt = S_RESP;
          else if (bus.req_op == OP_SW) w_state_nxt = S_WRITE;
          else                        w_state_nxt = S_READ;
        end
      end
      S_READ:  w_state_nxt = op_is_load(r_op) ? S_RESP : S_WRITE;
      S_WRITE: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  mem_access_unit_lsu_align u_align (
    .i_word    (bus.mem_rdata),
    .i_wdata   (r_wdata),
    .i_op      (r_op),
    .i_addr_lo (r_addr_lo),
    .o_rdata   (w_load_data),
    .o_word    (w_merged)
  );

  // Control outputs are registered from the next state so they switch cleanly at the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_op         <= '0;
      r_addr_lo    <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_mem_read   <= (w_state_nxt == S_READ);
      r_mem_write  <= (w_state_nxt == S_WRITE);
      r_resp_valid <= (w_state_nxt == S_RESP);
      if (w_accept) begin
        r_op         <= bus.req_op;
        r_addr_lo    <= bus.req_addr[1:0];
        r_wdata      <= bus.req_wdata[15:0];
        r_resp_err   <= w_req_err;
        r_resp_rdata <= '0;
        if (!w_req_err) begin
          r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
          r_mem_wdata <= bus.req_wdata;
        end
      end
      if (r_state == S_READ) begin
        if (op_is_load(r_op)) r_resp_rdata <= w_load_data;
        else                  r_mem_wdata  <= w_merged;
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_read   = r_mem_read;
  assign bus.mem_write  = r_mem_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized requests against a byte-level memory model.
module tb_mem_access_unit;

  localparam logic [31:0] LIMIT = 32'h0000_3000;

  logic clk;
  logic reset;
  mem_access_unit_if bus ();

  mem_access_unit #(.DATA_LIMIT(LIMIT)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the data port: asynchronous read, write at the clock edge.
  logic [31:0] mem [0:4095];
  logic        pl_we;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;

  assign bus.mem_rdata = mem[bus.mem_addr[13:2]];

  always @(posedge clk) begin
    if (bus.mem_write)  mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
    else if (pl_we)     mem[pl_idx] <= pl_data;
  end

  // Reference model: flat byte array, little-endian.
  logic [7:0] ref_b [0:16383];

  int n_cmp;
  int n_fail;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [13:0] b;
    b = {a[13:2], 2'b00};
    return {ref_b[b + 14'd3], ref_b[b + 14'd2], ref_b[b + 14'd1], ref_b[b]};
  endfunction

  function automatic int op_size(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0100, 4'b1000: return 1;
      4'b0001, 4'b0101, 4'b1001: return 2;
      4'b0011, 4'b1011:          return 4;
      default:                   return 0;
    endcase
  endfunction

  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag, output logic [31:0] obs_rdata, output logic obs_err);
    int          s;
    logic        is_st;
    logic        e_err;
    int          e_lat, e_rd, e_wr;
    logic [31:0] e_rdata, e_word, base, v;
    int          lat, n_rd, n_wr, n_both, n_badaddr;
    logic [31:0] last_wdata;
    logic        rdy;

    s     = op_size(op);
    is_st = (s != 0) && op[3];
    e_err = (s == 0) || (is_st && (addr >= LIMIT));
`ifdef LSU_MISALIGN_EXC_EN
    if (s > 1 && (addr % s) != 0) e_err = 1'b1;
`endif
    e_rdata = '0;
    e_word  = '0;
    e_lat = 1; e_rd = 0; e_wr = 0;
    if (!e_err) begin
      base = addr & ~(32'(s) - 32'd1);
      if (!is_st) begin
        v = '0;
        for (int k = 0; k < s; k++) v = v | (32'(ref_b[base[13:0] + 14'(k)]) << (8 * k));
        if (s < 4 && !op[2] && v[8*s-1]) v = v | ~((32'd1 << (8 * s)) - 32'd1);
        e_rdata = v;
        e_lat = 2; e_rd = 1;
      end else begin
        for (int k = 0; k < s; k++) ref_b[base[13:0] + 14'(k)] = wdata[8*k +: 8];
        e_word = ref_word(addr);
        e_lat = (s == 4) ? 2 : 3;
        e_rd  = (s == 4) ? 0 : 1;
        e_wr  = 1;
      end
    end

    rdy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin rdy = 1'b1; break; end
      @(negedge clk);
    end
    check32({tag, "_ready"}, 32'(rdy), 32'd1);

    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    lat = 0; n_rd = 0; n_wr = 0; n_both = 0; n_badaddr = 0;
    last_wdata = '0; obs_rdata = '0; obs_err = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.mem_read)  n_rd++;
      if (bus.mem_write) begin n_wr++; last_wdata = bus.mem_wdata; end
      if (bus.mem_read && bus.mem_write) n_both++;
      if ((bus.mem_read || bus.mem_write) && (bus.mem_addr !== (addr & ~32'd3))) n_badaddr++;
      if (bus.resp_valid) begin
        lat = c; obs_rdata = bus.resp_rdata; obs_err = bus.resp_err;
        break;
      end
    end
    check32({tag, "_latency"}, 32'(lat), 32'(e_lat));
    check32({tag, "_rdata"},   obs_rdata, e_rdata);
    check32({tag, "_err"},     32'(obs_err), 32'(e_err));
    check32({tag, "_nread"},   32'(n_rd), 32'(e_rd));
    check32({tag, "_nwrite"},  32'(n_wr), 32'(e_wr));
    check32({tag, "_rw_overlap"}, 32'(n_both), 32'd0);
    check32({tag, "_memaddr"}, 32'(n_badaddr), 32'd0);
    if (e_wr == 1) begin
      check32({tag, "_wdata"}, last_wdata, e_word);
      check32({tag, "_memword"}, mem[addr[13:2]], e_word);
    end
    @(negedge clk);
    check32({tag, "_pulse"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  logic [31:0] r;
  logic        e;
  logic [3:0]  op_tab [0:7];
  logic [3:0]  rop;
  logic [31:0] raddr;
  logic [31:0] v;

  initial begin
    n_cmp = 0; n_fail = 0;
    op_tab[0] = 4'b0000; op_tab[1] = 4'b0001; op_tab[2] = 4'b0011; op_tab[3] = 4'b0100;
    op_tab[4] = 4'b0101; op_tab[5] = 4'b1000; op_tab[6] = 4'b1001; op_tab[7] = 4'b1011;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    pl_we = 1'b0; pl_idx = '0; pl_data = '0;

    for (int w = 0; w < 4096; w++) begin
      v = (w == 4) ? 32'h8899AABB : $urandom;
      pl_idx = w[11:0]; pl_data = v; pl_we = 1'b1;
      for (int k = 0; k < 4; k++) ref_b[w * 4 + k] = v[8*k +: 8];
      @(negedge clk);
    end
    pl_we = 1'b0;
    @(negedge clk);

    check32("rst_ready",  {31'd0, bus.req_ready},  32'd1);
    check32("rst_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    check32("rst_mread",  {31'd0, bus.mem_read},   32'd0);
    check32("rst_mwrite", {31'd0, bus.mem_write},  32'd0);
    check32("rst_rdata",  bus.resp_rdata, 32'd0);
    check32("rst_maddr",  bus.mem_addr,   32'd0);
    reset = 1'b0;
    @(negedge clk);
    check32("rel_ready", {31'd0, bus.req_ready}, 32'd1);

    run_txn(4'b0000, 32'h13, 32'h0, "lb13", r, e);   check32("lb13_lit",  r, 32'hFFFFFF88);
    run_txn(4'b0101, 32'h12, 32'h0, "lhu12", r, e);  check32("lhu12_lit", r, 32'h00008899);
    run_txn(4'b0001, 32'h12, 32'h0, "lh12", r, e);   check32("lh12_lit",  r, 32'hFFFF8899);
    run_txn(4'b0100, 32'h10, 32'h0, "lbu10", r, e);  check32("lbu10_lit", r, 32'h000000BB);
    run_txn(4'b0011, 32'h12, 32'h0, "lw12", r, e);
`ifdef LSU_MISALIGN_EXC_EN
    check32("lw12_lit_err", {31'd0, e}, 32'd1);
    check32("lw12_lit", r, 32'h0);
`else
    check32("lw12_lit_err", {31'd0, e}, 32'd0);
    check32("lw12_lit", r, 32'h8899AABB);
`endif
    run_txn(4'b1000, 32'h11, 32'h000000CC, "sb11", r, e);
    check32("sb11_lit_mem", mem[4], 32'h8899CCBB);
    run_txn(4'b0011, 32'h10, 32'h0, "lw10", r, e);   check32("lw10_lit", r, 32'h8899CCBB);
    run_txn(4'b1011, 32'h3000, 32'hDEADBEEF, "sw3000", r, e);
    check32("sw3000_lit_err", {31'd0, e}, 32'd1);
    run_txn(4'b1011, 32'h2FFC, 32'h12345678, "sw2ffc", r, e);
    run_txn(4'b0111, 32'h20, 32'h0, "op0111", r, e);
    check32("op0111_lit_err", {31'd0, e}, 32'd1);

    // Reset while SH is in its READ cycle.
    bus.req_valid = 1'b1; bus.req_op = 4'b1001; bus.req_addr = 32'h10; bus.req_wdata = 32'h0000_5A5A;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check32("rstmid_inread", {31'd0, bus.mem_read}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check32("rstmid_mread",  {31'd0, bus.mem_read},   32'd0);
    check32("rstmid_mwrite", {31'd0, bus.mem_write},  32'd0);
    check32("rstmid_rvalid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int n_bad;
      n_bad = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bus.mem_write || bus.resp_valid || !bus.req_ready) n_bad++;
      end
      check32("rstmid_quiet", 32'(n_bad), 32'd0);
    end
    check32("rstmid_word", mem[4], ref_word(32'h10));
    check32("rstmid_lit",  mem[4], 32'h8899CCBB);

    for (int t = 0; t < 300; t++) begin
      rop = ($urandom_range(0, 9) < 8) ? op_tab[$urandom_range(0, 7)] : 4'($urandom);
      if ($urandom_range(0, 3) == 0) raddr = 32'h2FF0 + $urandom_range(0, 31);
      else                           raddr = $urandom_range(0, 16383);
      run_txn(rop, raddr, $urandom, $sformatf("rnd%0d_op%b_a%h", t, rop, raddr), r, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
